// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key scheduler: accepts a cipher key, expands round keys 0..10 one
// per clock into a register table, and exposes the table flat and through an indexed port.
module aes_key_sched_seq #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_W-1:0]        key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic                    busy,
  output logic                    keys_valid,
  output logic [(NR+1)*KEY_W-1:0] rk_all,
  input  logic [3:0]              rk_sel,
  output logic [KEY_W-1:0]        rk_out
);

  if (NR != 10 || KEY_W != 128) begin : g_bad_params
    $error("aes_key_sched_seq supports only NR=10, KEY_W=128");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXPAND = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, byte 0 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit 2047-8*b, which is {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [KEY_W-1:0] r_rk [NR+1];

  logic             w_accept;
  logic             w_last;
  logic [KEY_W-1:0] w_prev;
  logic [31:0]      w_rot;
  logic [31:0]      w_t;
  logic [31:0]      w_w0;
  logic [31:0]      w_w1;
  logic [31:0]      w_w2;
  logic [31:0]      w_w3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    busy        = 1'b0;
    keys_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_state_nxt = S_EXPAND;
      end
      S_EXPAND: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_valid) w_state_nxt = S_EXPAND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = key_valid & key_ready;
  assign w_last   = (r_cnt == LAST);

  // One FIPS-197 round step, fed only from the previous table entry.
  assign w_prev = r_rk[r_cnt - 4'd1];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};
  assign w_t    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                  ^ {rcon(r_cnt), 24'h0};
  assign w_w0   = w_prev[127:96] ^ w_t;
  assign w_w1   = w_prev[95:64]  ^ w_w0;
  assign w_w2   = w_prev[63:32]  ^ w_w1;
  assign w_w3   = w_prev[31:0]   ^ w_w2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is built from flops, so it is cleared by reset like any other state;
      // nothing may survive an aborted expansion.
      r_cnt <= 4'd0;
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else if (w_accept) begin
      r_rk[0] <= key_in;
      r_cnt   <= 4'd1;
    end else if (r_state == S_EXPAND) begin
      r_rk[r_cnt] <= {w_w0, w_w1, w_w2, w_w3};
      r_cnt       <= r_cnt + 4'd1;
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_flat
    assign rk_all[KEY_W*g +: KEY_W] = r_rk[g];
  end

  assign rk_out = (rk_sel <= LAST) ? r_rk[rk_sel] : '0;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboard bench for aes_key_sched_seq: a word-level FIPS-197 key expansion model
// (S-box derived from GF(2^8) arithmetic) and an inverse-cipher check of the table.
module tb_aes_key_sched_seq;

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   key_in;
  logic           key_valid;
  logic           key_ready;
  logic           busy;
  logic           keys_valid;
  logic [1407:0]  rk_all;
  logic [3:0]     rk_sel;
  logic [127:0]   rk_out;

  always #5 clk = ~clk;

  aes_key_sched_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_all     (rk_all),
    .rk_sel     (rk_sel),
    .rk_out     (rk_out)
  );

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0_RK10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] CT     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1407:0] tbl;
    time           acc_t;
  } exp_t;

  exp_t          sb[$];
  logic [1407:0] cur_tbl;
  logic [7:0]    sbox_m  [256];
  logic [7:0]    isbox_m [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x]  = s;
      isbox_m[s] = 8'(x);
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] tbl;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) tbl[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return tbl;
  endfunction

  function automatic logic [127:0] decrypt(input logic [1407:0] tbl, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] rk;
    logic [127:0] out;
    rk = tbl[1280 +: 128];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          t[row + 4*c] = s[row + 4*((c - row + 4) % 4)];
      rk = tbl[128*r +: 128];
      for (int i = 0; i < 16; i++) s[i] = isbox_m[t[i]] ^ rk[127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c + j];
          s[4*c]   = gmul(a[0], 8'd14) ^ gmul(a[1], 8'd11) ^ gmul(a[2], 8'd13) ^ gmul(a[3], 8'd9);
          s[4*c+1] = gmul(a[0], 8'd9)  ^ gmul(a[1], 8'd14) ^ gmul(a[2], 8'd11) ^ gmul(a[3], 8'd13);
          s[4*c+2] = gmul(a[0], 8'd13) ^ gmul(a[1], 8'd9)  ^ gmul(a[2], 8'd14) ^ gmul(a[3], 8'd11);
          s[4*c+3] = gmul(a[0], 8'd11) ^ gmul(a[1], 8'd13) ^ gmul(a[2], 8'd9)  ^ gmul(a[3], 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- monitor ----------------
  logic prev_kv = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_kv = 1'b0;
    end else begin
      if (keys_valid && !prev_kv) begin
        if (sb.size() == 0) begin
          check("unexpected_keys_valid", 128'(keys_valid), 128'd0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 11; i++)
            check($sformatf("table_rk%0d", i), rk_all[128*i +: 128], e.tbl[128*i +: 128]);
          check("keys_valid_latency", 128'(($time - 5 - e.acc_t) / 10), 128'd10);
        end
      end
      prev_kv = keys_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_key(input logic [127:0] k);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    while (!key_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      check("accept_timeout", 128'(key_ready), 128'd1);
      key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.tbl   = expand(k);
    e.acc_t = $time;
    sb.push_back(e);
    cur_tbl = e.tbl;
    #1 key_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!keys_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 128'(keys_valid), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    int           s;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_sel    = 4'd0;
    build_sbox();

    // Reset state
    #3;
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_keys_valid", 128'(keys_valid), 128'd0);
    for (int i = 0; i < 11; i++) check($sformatf("rst_rk%0d", i), rk_all[128*i +: 128], 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIPS-197 App.A key, end-to-end decrypt, rk_sel sweep
    send_key(K1);
    check("expand_key_ready", 128'(key_ready), 128'd0);
    wait_done();
    check("k1_rk0", rk_all[0 +: 128], K1);
    check("k1_rk1", rk_all[128 +: 128], K1_RK1);
    check("k1_rk10", rk_all[1280 +: 128], K1_RK10);
    check("decrypt_fips", decrypt(rk_all, CT), PT);
    for (int i = 0; i < 16; i++) begin
      rk_sel = 4'(i);
      #1;
      check($sformatf("rk_out_sel%0d", i), rk_out, (i <= 10) ? cur_tbl[128*i +: 128] : 128'd0);
    end

    // All-zero key accepted directly in DONE
    send_key(128'd0);
    check("redo_keys_valid_drop", 128'(keys_valid), 128'd0);
    check("redo_busy", 128'(busy), 128'd1);
    repeat (5) @(negedge clk);
    check("redo_busy_mid", 128'(busy), 128'd1);
    wait_done();
    check("k0_rk1", rk_all[128 +: 128], K0_RK1);
    check("k0_rk10", rk_all[1280 +: 128], K0_RK10);
    check("k0_busy_done", 128'(busy), 128'd0);

    // Foreign key pulsed during EXPAND must be ignored
    send_key(K1);
    repeat (2) @(negedge clk);
    key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_valid = 1'b1;
    #1 check("pulse_key_ready", 128'(key_ready), 128'd0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_done();
    check("pulse_rk10", rk_all[1280 +: 128], K1_RK10);
    @(negedge clk);
    check("pulse_no_restart", 128'(keys_valid), 128'd1);

    // Reset in the middle of an expansion (cnt = 5)
    send_key({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (4) @(posedge clk);
    #2 check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_key_ready", 128'(key_ready), 128'd1);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
    for (int i = 0; i < 11; i++) check($sformatf("mid_rst_rk%0d", i), rk_all[128*i +: 128], 128'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_key({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_done();

    // Randomized keys with idle gaps and random reads
    for (int it = 0; it < 6; it++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_key(k);
      wait_done();
      for (int j = 0; j < 3; j++) begin
        s      = int'($urandom_range(0, 15));
        rk_sel = 4'(s);
        #1;
        check($sformatf("rand_rk_out_sel%0d", s), rk_out, (s <= 10) ? cur_tbl[128*s +: 128] : 128'd0);
      end
    end

    @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
